// File: rtl/ap_ctrl_chain_driver.sv
// Stimulus-side ap_ctrl_chain driver: issues a programmed number of kernel
// transactions, tracks completions and run latency, and flags stalled handshakes.
module ap_ctrl_chain_driver #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned LAT_W      = 32,
  parameter int unsigned CONT_DELAY = 0,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] num_trans,
  output logic             ap_start,
  output logic             ap_continue,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_idle,
  output logic             finish,
  output logic             busy,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [LAT_W-1:0] last_latency,
  output logic             timeout_err
);

  localparam int unsigned PROG_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned DLY_W  = (CONT_DELAY < 2) ? 1 : $clog2(CONT_DELAY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FINISH,
    S_ERROR
  } state_t;

  state_t            state;
  logic              enable_q;
  logic [CNT_W-1:0]  n_q;
  logic [LAT_W-1:0]  lat_cnt;
  logic [PROG_W-1:0] prog_cnt;
  logic [DLY_W-1:0]  cont_cnt;
  logic              cont_active;

  logic accept_c;
  logic count_c;
  logic last_issue_c;
  logic last_done_c;
  logic timeout_c;

  // Handshake events for the current cycle; ap_start/ap_continue are only
  // ever high in RUN/DRAIN, so no extra state qualification is needed.
  always_comb begin
    accept_c     = ap_start & ap_ready;
    count_c      = ap_done & ap_continue & (done_cnt != n_q);
    last_issue_c = accept_c & (CNT_W'(issued_cnt + CNT_W'(1)) == n_q);
    last_done_c  = count_c & (CNT_W'(done_cnt + CNT_W'(1)) == n_q);
    timeout_c    = (TIMEOUT != 0) & ~accept_c & ~count_c &
                   (prog_cnt == PROG_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      enable_q     <= 1'b0;
      n_q          <= '0;
      lat_cnt      <= '0;
      prog_cnt     <= '0;
      cont_cnt     <= '0;
      cont_active  <= 1'b0;
      ap_start     <= 1'b0;
      ap_continue  <= 1'b0;
      finish       <= 1'b0;
      busy         <= 1'b0;
      issued_cnt   <= '0;
      done_cnt     <= '0;
      last_latency <= '0;
      timeout_err  <= 1'b0;
    end else begin
      enable_q <= enable;
      case (state)
        S_IDLE: begin
          if (enable && !enable_q) begin
            n_q          <= num_trans;
            issued_cnt   <= '0;
            done_cnt     <= '0;
            last_latency <= '0;
            lat_cnt      <= '0;
            prog_cnt     <= '0;
            cont_cnt     <= '0;
            cont_active  <= 1'b0;
            if (num_trans == '0) begin
              state  <= S_FINISH;
              finish <= 1'b1;
            end else begin
              state       <= S_RUN;
              ap_start    <= 1'b1;
              ap_continue <= (CONT_DELAY == 0);
              busy        <= 1'b1;
            end
          end
        end

        S_RUN, S_DRAIN: begin
          if (lat_cnt != '1) lat_cnt <= lat_cnt + LAT_W'(1);
          if (accept_c) issued_cnt <= issued_cnt + CNT_W'(1);
          if (count_c) done_cnt <= done_cnt + CNT_W'(1);
          if (last_done_c) last_latency <= lat_cnt;

          // Delayed continue: arm on a new ap_done, pulse CONT_DELAY cycles later.
          if (CONT_DELAY != 0) begin
            ap_continue <= 1'b0;
            if (cont_active) begin
              if (cont_cnt <= DLY_W'(1)) begin
                ap_continue <= 1'b1;
                cont_active <= 1'b0;
              end else begin
                cont_cnt <= cont_cnt - DLY_W'(1);
              end
            end else if (ap_done && !ap_continue && (done_cnt != n_q)) begin
              if (CONT_DELAY == 1) begin
                ap_continue <= 1'b1;
              end else begin
                cont_active <= 1'b1;
                cont_cnt    <= DLY_W'(CONT_DELAY - 1);
              end
            end
          end

          if (accept_c || count_c) begin
            prog_cnt <= '0;
          end else if (TIMEOUT != 0) begin
            prog_cnt <= prog_cnt + PROG_W'(1);
          end

          if ((state == S_DRAIN) && (done_cnt == n_q)) begin
            state       <= S_FINISH;
            finish      <= 1'b1;
            busy        <= 1'b0;
            ap_start    <= 1'b0;
            ap_continue <= 1'b0;
            cont_active <= 1'b0;
          end else if (timeout_c) begin
            state       <= S_ERROR;
            timeout_err <= 1'b1;
            finish      <= 1'b0;
            busy        <= 1'b0;
            ap_start    <= 1'b0;
            ap_continue <= 1'b0;
            cont_active <= 1'b0;
          end else if ((state == S_RUN) && last_issue_c) begin
            state    <= S_DRAIN;
            ap_start <= 1'b0;
          end
        end

        S_FINISH: begin
          if (!enable) begin
            state  <= S_IDLE;
            finish <= 1'b0;
          end
        end

        S_ERROR: begin
          ap_start    <= 1'b0;
          ap_continue <= 1'b0;
          finish      <= 1'b0;
          busy        <= 1'b0;
          timeout_err <= 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // The kernel must report idle once the whole run has drained.
  always_ff @(posedge clock) begin
    if (!reset && (state == S_FINISH)) begin
      assert (ap_idle) else $error("ap_idle low while run is finished");
    end
  end

endmodule

// File: tb/tb_ap_ctrl_chain_driver.sv
// Directed bench for ap_ctrl_chain_driver: one instance with immediate continue,
// one with delayed continue, both with a short handshake timeout.
module tb_ap_ctrl_chain_driver;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_a, en_a, rdy_a, dn_a;
  logic [15:0] num_a;
  logic        st_a, ct_a, fin_a, busy_a, to_a;
  logic [15:0] iss_a, dcnt_a;
  logic [31:0] lat_a;

  logic        rst_b, en_b, rdy_b, dn_b;
  logic [15:0] num_b;
  logic        st_b, ct_b, fin_b, busy_b, to_b;
  logic [15:0] iss_b, dcnt_b;
  logic [31:0] lat_b;

  logic idle = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  ap_ctrl_chain_driver #(.CNT_W(16), .LAT_W(32), .CONT_DELAY(0), .TIMEOUT(20)) u_a (
    .clock(clock), .reset(rst_a), .enable(en_a), .num_trans(num_a),
    .ap_start(st_a), .ap_continue(ct_a), .ap_ready(rdy_a), .ap_done(dn_a),
    .ap_idle(idle), .finish(fin_a), .busy(busy_a), .issued_cnt(iss_a),
    .done_cnt(dcnt_a), .last_latency(lat_a), .timeout_err(to_a)
  );

  ap_ctrl_chain_driver #(.CNT_W(16), .LAT_W(32), .CONT_DELAY(4), .TIMEOUT(20)) u_b (
    .clock(clock), .reset(rst_b), .enable(en_b), .num_trans(num_b),
    .ap_start(st_b), .ap_continue(ct_b), .ap_ready(rdy_b), .ap_done(dn_b),
    .ap_idle(idle), .finish(fin_b), .busy(busy_b), .issued_cnt(iss_b),
    .done_cnt(dcnt_b), .last_latency(lat_b), .timeout_err(to_b)
  );

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [67:0] obs;
    rst_a = 1'b1; rst_b = 1'b1;
    tick(); tick();
    obs = {st_a, ct_a, fin_a, busy_a, iss_a, dcnt_a, lat_a, to_a};
    n_cmp++;
    if (obs !== 68'h0) begin n_err++; $display("FAIL reset_a: got %h want 0", obs); end
    obs = {st_b, ct_b, fin_b, busy_b, iss_b, dcnt_b, lat_b, to_b};
    n_cmp++;
    if (obs !== 68'h0) begin n_err++; $display("FAIL reset_b: got %h want 0", obs); end
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [11:0] m_start, m_cont, m_fin, m_busy;
    num_a = 16'd3; rdy_a = 1'b1; dn_a = 1'b0; en_a = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      m_start[i] = st_a; m_cont[i] = ct_a; m_fin[i] = fin_a; m_busy[i] = busy_a;
      dn_a = (i >= 5 && i <= 7);
      tick();
    end
    n_cmp++;
    if (m_start !== 12'h007) begin n_err++; $display("FAIL basic_start: got %h want 007", m_start); end
    n_cmp++;
    if (m_cont !== 12'h1FF) begin n_err++; $display("FAIL basic_cont: got %h want 1ff", m_cont); end
    n_cmp++;
    if (m_busy !== 12'h1FF) begin n_err++; $display("FAIL basic_busy: got %h want 1ff", m_busy); end
    n_cmp++;
    if (m_fin !== 12'hE00) begin n_err++; $display("FAIL basic_finish: got %h want e00", m_fin); end
    n_cmp++;
    if (iss_a !== 16'd3 || dcnt_a !== 16'd3) begin
      n_err++; $display("FAIL basic_counts: got %0d/%0d want 3/3", iss_a, dcnt_a);
    end
    n_cmp++;
    if (lat_a !== 32'd7) begin n_err++; $display("FAIL basic_latency: got %0d want 7", lat_a); end
    en_a = 1'b0;
    tick();
    n_cmp++;
    if (fin_a !== 1'b0 || busy_a !== 1'b0) begin
      n_err++; $display("FAIL basic_release: got fin=%b busy=%b want 0/0", fin_a, busy_a);
    end
  endtask

  task automatic test_zero();
    logic [65:0] obs;
    num_a = 16'd0; en_a = 1'b1;
    tick();
    n_cmp++;
    if (fin_a !== 1'b1) begin n_err++; $display("FAIL zero_finish: got %b want 1", fin_a); end
    obs = {st_a, ct_a, iss_a, dcnt_a, lat_a};
    n_cmp++;
    if (obs !== 66'h0) begin n_err++; $display("FAIL zero_quiet: got %h want 0", obs); end
    en_a = 1'b0;
    tick();
    n_cmp++;
    if (fin_a !== 1'b0 || st_a !== 1'b0) begin
      n_err++; $display("FAIL zero_release: got fin=%b start=%b want 0/0", fin_a, st_a);
    end
  endtask

  task automatic test_cont_delay();
    logic [19:0] m_start, m_cont, m_fin;
    logic [15:0] d_at [20];
    num_b = 16'd2; rdy_b = 1'b1; dn_b = 1'b0; en_b = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      m_start[i] = st_b; m_cont[i] = ct_b; m_fin[i] = fin_b; d_at[i] = dcnt_b;
      dn_b = (i >= 3 && i <= 7) || (i >= 10 && i <= 14);
      tick();
    end
    n_cmp++;
    if (m_start !== 20'h00003) begin n_err++; $display("FAIL cdly_start: got %h want 00003", m_start); end
    n_cmp++;
    if (m_cont !== 20'h04080) begin n_err++; $display("FAIL cdly_cont: got %h want 04080", m_cont); end
    n_cmp++;
    if (d_at[7] !== 16'd0 || d_at[8] !== 16'd1 || d_at[14] !== 16'd1 || d_at[15] !== 16'd2) begin
      n_err++;
      $display("FAIL cdly_steps: got %0d,%0d,%0d,%0d want 0,1,1,2", d_at[7], d_at[8], d_at[14], d_at[15]);
    end
    n_cmp++;
    if (m_fin !== 20'hF0000) begin n_err++; $display("FAIL cdly_finish: got %h want f0000", m_fin); end
    n_cmp++;
    if (iss_b !== 16'd2 || lat_b !== 32'd14) begin
      n_err++; $display("FAIL cdly_final: got iss=%0d lat=%0d want 2/14", iss_b, lat_b);
    end
    en_b = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    logic [24:0] m_to, m_start, m_fin;
    num_a = 16'd5; rdy_a = 1'b0; dn_a = 1'b0; en_a = 1'b1;
    tick();
    for (int i = 0; i < 25; i++) begin
      m_to[i] = to_a; m_start[i] = st_a; m_fin[i] = fin_a;
      tick();
    end
    n_cmp++;
    if (m_to !== 25'h1F00000) begin n_err++; $display("FAIL tmo_flag: got %h want 1f00000", m_to); end
    n_cmp++;
    if (m_start !== 25'h00FFFFF) begin n_err++; $display("FAIL tmo_start: got %h want 00fffff", m_start); end
    n_cmp++;
    if (m_fin !== 25'h0) begin n_err++; $display("FAIL tmo_finish: got %h want 0", m_fin); end
    en_a = 1'b0;
    tick(); tick();
    n_cmp++;
    if (to_a !== 1'b1 || fin_a !== 1'b0 || st_a !== 1'b0 || ct_a !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_sticky: got to=%b fin=%b st=%b ct=%b want 1/0/0/0", to_a, fin_a, st_a, ct_a);
    end
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    n_cmp++;
    if (to_a !== 1'b0) begin n_err++; $display("FAIL tmo_clear: got %b want 0", to_a); end
    tick();
  endtask

  task automatic test_reset_drain();
    logic [67:0] obs;
    logic [6:0]  m_fin;
    num_a = 16'd2; rdy_a = 1'b1; dn_a = 1'b0; en_a = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      dn_a = (i == 3);
      tick();
    end
    n_cmp++;
    if (iss_a !== 16'd2 || dcnt_a !== 16'd1 || busy_a !== 1'b1) begin
      n_err++; $display("FAIL rstd_pre: got iss=%0d done=%0d busy=%b want 2/1/1", iss_a, dcnt_a, busy_a);
    end
    rst_a = 1'b1; en_a = 1'b0;
    tick();
    obs = {st_a, ct_a, fin_a, busy_a, iss_a, dcnt_a, lat_a, to_a};
    n_cmp++;
    if (obs !== 68'h0) begin n_err++; $display("FAIL rstd_abort: got %h want 0", obs); end
    rst_a = 1'b0;
    tick();
    en_a = 1'b1;
    tick();
    n_cmp++;
    if (st_a !== 1'b1 || busy_a !== 1'b1 || iss_a !== 16'd0 || dcnt_a !== 16'd0) begin
      n_err++;
      $display("FAIL rstd_restart: got st=%b busy=%b iss=%0d done=%0d want 1/1/0/0", st_a, busy_a, iss_a, dcnt_a);
    end
    for (int i = 0; i < 7; i++) begin
      m_fin[i] = fin_a;
      dn_a = (i == 2 || i == 3);
      tick();
    end
    n_cmp++;
    if (m_fin !== 7'h60 || iss_a !== 16'd2 || dcnt_a !== 16'd2 || lat_a !== 32'd3) begin
      n_err++;
      $display("FAIL rstd_rerun: got fin=%h iss=%0d done=%0d lat=%0d want 60/2/2/3", m_fin, iss_a, dcnt_a, lat_a);
    end
    en_a = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  m_start, m_fin;
    logic [15:0] iss_at [8];
    logic [15:0] dn_at  [8];
    num_a = 16'd4; rdy_a = 1'b1; dn_a = 1'b0; en_a = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      m_start[i] = st_a; m_fin[i] = fin_a; iss_at[i] = iss_a; dn_at[i] = dcnt_a;
      dn_a = (i >= 1 && i <= 4);
      tick();
    end
    n_cmp++;
    if (m_start !== 8'h0F) begin n_err++; $display("FAIL b2b_start: got %h want 0f", m_start); end
    n_cmp++;
    if (iss_at[2] !== 16'd2 || dn_at[2] !== 16'd1 || iss_at[3] !== 16'd3 || dn_at[3] !== 16'd2) begin
      n_err++;
      $display("FAIL b2b_overlap: got %0d/%0d %0d/%0d want 2/1 3/2", iss_at[2], dn_at[2], iss_at[3], dn_at[3]);
    end
    n_cmp++;
    if (iss_a !== 16'd4 || dcnt_a !== 16'd4 || lat_a !== 32'd4) begin
      n_err++; $display("FAIL b2b_final: got iss=%0d done=%0d lat=%0d want 4/4/4", iss_a, dcnt_a, lat_a);
    end
    n_cmp++;
    if (m_fin !== 8'hC0) begin n_err++; $display("FAIL b2b_finish: got %h want c0", m_fin); end
    en_a = 1'b0;
    tick();
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b0; rdy_a = 1'b0; dn_a = 1'b0; num_a = '0;
    rst_b = 1'b1; en_b = 1'b0; rdy_b = 1'b0; dn_b = 1'b0; num_b = '0;
    test_reset();
    test_basic();
    test_zero();
    test_cont_delay();
    test_timeout();
    test_reset_drain();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_chain_driver.md
Name: ap_ctrl_chain_driver

Overview:
- Synthesizable stimulus-side counterpart to the dataflow status monitor: drives the ap_ctrl_chain handshake (ap_start, ap_continue) into a kernel under test for a programmed number of transactions.
- Observes ap_ready, ap_done and ap_idle, and asserts finish when the run is complete; finish feeds the monitor's finish input directly.
- Counts issued and completed transactions, measures run latency and flags handshake timeouts.
- Sits in the co-sim top between the testbench control and the DUT block-level control ports.

Parameters:
- CNT_W, 16, width of transaction counters and num_trans.
- LAT_W, 32, width of the cycle/latency counter.
- CONT_DELAY, 0, cycles of back-pressure applied after ap_done is seen before ap_continue pulses; 0 means ap_continue is held high throughout the run.
- TIMEOUT, 100000, cycles with no handshake progress before the error state; 0 disables the timeout.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; rising edge detected while IDLE starts a run.
- num_trans  in  CNT_W  transactions to issue; sampled at run start.
- ap_start  out  1  to DUT.
- ap_continue  out  1  to DUT.
- ap_ready  in  1  from DUT.
- ap_done  in  1  from DUT.
- ap_idle  in  1  from DUT.
- finish  out  1  run complete; to the monitor's finish input.
- busy  out  1  high in RUN or DRAIN.
- issued_cnt  out  CNT_W  transactions accepted (ap_start & ap_ready).
- done_cnt  out  CNT_W  transactions completed (ap_done & ap_continue).
- last_latency  out  LAT_W  cycles from run start to final completion.
- timeout_err  out  1  sticky handshake-timeout flag.

Behaviour:
- One clock, `clock`; reset is synchronous and active-high, on port `reset`.
- All outputs registered. Reset values: ap_start=0, ap_continue=0, finish=0, busy=0, all counters=0, timeout_err=0, state=IDLE. Reset mid-run aborts immediately and returns to IDLE the next edge; no partial finish.
- States:
  - IDLE: wait for an enable rising edge (enable=1 with the registered previous enable=0). On that edge latch num_trans as N, clear the counters and the latency counter, then:
    - N=0: go to FINISH.
    - Otherwise go to RUN; ap_start=1 on the next cycle.
  - RUN:
    - ap_start stays high until issued_cnt reaches N.
    - Acceptance is a cycle where ap_start & ap_ready = 1; issued_cnt increments then.
    - If the acceptance makes issued_cnt equal N, ap_start drops the following cycle and the state moves to DRAIN.
    - Back-to-back acceptances are legal: ap_start does not drop between them.
  - DRAIN: wait until done_cnt reaches N, then go to FINISH.
  - FINISH: finish=1 and busy=0. Hold FINISH while enable=1; when enable=0, go to IDLE and finish=0.
  - ERROR: ap_start=0, ap_continue=0, finish=0, timeout_err=1. Only reset exits ERROR.
- Completion handling (RUN and DRAIN):
  - CONT_DELAY=0: ap_continue=1 for the whole run. A completion is counted in every cycle with ap_done=1.
  - CONT_DELAY>0: ap_continue is held at 0 by default.
    - On the first cycle with ap_done=1, load a down-counter with CONT_DELAY.
    - When the counter reaches 0, ap_continue=1 for exactly one cycle; the completion is counted in that cycle if ap_done=1.
    - ap_done deasserting before the continue pulse is a DUT protocol violation; the driver ignores it and does not count it.
- Simultaneous acceptance and completion in one cycle update both counters.
- done_cnt never exceeds N; extra ap_done pulses after N are ignored.
- Latency: a free-running counter starts at 0 on the cycle after run start and increments every cycle in RUN/DRAIN. It is copied to last_latency on the cycle the Nth completion is counted. The copy saturates at all-ones and does not wrap.
- Timeout:
  - The progress counter resets on any acceptance or counted completion and increments otherwise in RUN/DRAIN.
  - When it reaches TIMEOUT, go to ERROR.
- ap_idle is informational only: it is used solely to assert, in simulation, that ap_idle=1 in FINISH.

Test Plan:
- N=3, DUT ready immediately, done 5 cycles after each accept, CONT_DELAY=0 -> issued_cnt=3; ap_start high for 3 consecutive accept cycles; done_cnt=3; finish=1 held until enable drops; last_latency = cycle of 3rd done minus start.
- num_trans=0, enable pulse -> FINISH the next cycle with finish=1; ap_start and ap_continue never assert; counters stay 0.
- CONT_DELAY=4, N=2, ap_done held high -> ap_continue pulses exactly once, 4 cycles after each ap_done rise; done_cnt steps 1 then 2.
- TIMEOUT=20, DUT never asserts ap_ready -> ERROR after 20 cycles: timeout_err=1, ap_start=0, finish stays 0 until reset.
- Reset asserted while in DRAIN with done_cnt=1 of 2 -> next cycle all outputs are 0 and state is IDLE; a fresh enable edge starts a clean run.
- Accept and done coincide in one cycle (pipelined DUT, N=4) -> both counters increment in that cycle; final issued_cnt=done_cnt=4.
